// File: rtl/snn_packet_feeder.sv
// rtl/snn_packet_feeder.sv - boot-ROM packet source and spike capture for SNN_3x2
module snn_packet_feeder #(
    parameter int PKT_W          = 30,
    parameter int NUM_OUTPUT     = 250,
    parameter int CNT_W          = 12,
    parameter int PKT_AW         = 14,
    parameter int PIC_W          = 8,
    parameter int OUT_AW         = 8,
    parameter int WARMUP         = 3,
    parameter logic [2:0] GRID_DONE = 3'd7
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [PIC_W-1:0]      num_picture,
    output logic [PIC_W-1:0]      cnt_raddr,
    input  logic [CNT_W-1:0]      cnt_rdata,
    output logic [PKT_AW-1:0]     pkt_raddr,
    input  logic [PKT_W-1:0]      pkt_rdata,
    output logic                  packet_winc,
    output logic [PKT_W-1:0]      packet_wdata,
    output logic                  spike_en,
    output logic                  load_end,
    input  logic [2:0]            grid_state,
    input  logic                  tick_ready,
    input  logic [NUM_OUTPUT-1:0] spike_out,
    input  logic                  complete,
    output logic                  out_wen,
    output logic [OUT_AW-1:0]     out_waddr,
    output logic [NUM_OUTPUT-1:0] out_wdata,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_CNT,
        S_LAT_CNT,
        S_RD_PKT,
        S_WR_PKT,
        S_WAIT_GRID,
        S_LOAD_END
    } state_t;

    state_t             state, state_n;
    logic [PIC_W-1:0]   pic, pic_n;
    logic [PIC_W-1:0]   num_pic, num_pic_n;
    logic [CNT_W-1:0]   remaining, remaining_n;
    logic [PKT_AW-1:0]  pkt_ptr, pkt_ptr_n;
    logic               done_seen, done_seen_n;
    logic               done_n;
    logic               spike_en_n;
    logic               grid_done_d;
    logic               grid_rise;
    logic               tick_d;
    logic [OUT_AW-1:0]  line;
    logic [PKT_W-1:0]   wdata_hold;

    assign grid_rise    = (grid_state == GRID_DONE) && !grid_done_d;
    assign cnt_raddr    = pic;
    assign pkt_raddr    = pkt_ptr;
    assign busy         = (state != S_IDLE);
    assign load_end     = (state == S_LOAD_END);
    assign packet_winc  = (state == S_WR_PKT);
    assign packet_wdata = (state == S_WR_PKT) ? pkt_rdata : wdata_hold;
    assign out_waddr    = line - OUT_AW'(1);

    // Next-state and next-counter logic for the picture/packet sequencer
    always_comb begin
        state_n     = state;
        pic_n       = pic;
        num_pic_n   = num_pic;
        remaining_n = remaining;
        pkt_ptr_n   = pkt_ptr;
        done_seen_n = done_seen;
        done_n      = 1'b0;

        // A GRID_DONE rise only counts once this picture's count has been latched
        if (grid_rise && (state == S_RD_PKT || state == S_WR_PKT || state == S_WAIT_GRID))
            done_seen_n = 1'b1;

        case (state)
            S_IDLE: begin
                if (start) begin
                    num_pic_n = num_picture;
                    pic_n     = '0;
                    state_n   = (num_picture == '0) ? S_LOAD_END : S_RD_CNT;
                end
            end
            S_RD_CNT: state_n = S_LAT_CNT;
            S_LAT_CNT: begin
                remaining_n = cnt_rdata;
                done_seen_n = 1'b0;
                state_n     = (cnt_rdata == '0) ? S_WAIT_GRID : S_RD_PKT;
            end
            S_RD_PKT: state_n = S_WR_PKT;
            S_WR_PKT: begin
                pkt_ptr_n   = pkt_ptr + PKT_AW'(1);
                remaining_n = remaining - CNT_W'(1);
                state_n     = (remaining == CNT_W'(1)) ? S_WAIT_GRID : S_RD_PKT;
            end
            S_WAIT_GRID: begin
                if (done_seen) begin
                    if (pic == num_pic - PIC_W'(1)) begin
                        state_n = S_LOAD_END;
                    end else begin
                        pic_n   = pic + PIC_W'(1);
                        state_n = S_RD_CNT;
                    end
                end
            end
            S_LOAD_END: begin
                if (complete) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        spike_en_n = (state_n != S_IDLE) && (pic_n >= PIC_W'(WARMUP));
    end

    // Sequencer state, counters and registered control outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            pic         <= '0;
            num_pic     <= '0;
            remaining   <= '0;
            pkt_ptr     <= '0;
            done_seen   <= 1'b0;
            done        <= 1'b0;
            spike_en    <= 1'b0;
            grid_done_d <= 1'b0;
            wdata_hold  <= '0;
        end else begin
            state       <= state_n;
            pic         <= pic_n;
            num_pic     <= num_pic_n;
            remaining   <= remaining_n;
            pkt_ptr     <= pkt_ptr_n;
            done_seen   <= done_seen_n;
            done        <= done_n;
            spike_en    <= spike_en_n;
            grid_done_d <= (grid_state == GRID_DONE);
            if (state == S_WR_PKT)
                wdata_hold <= pkt_rdata;
        end
    end

    // Spike capture: one output RAM line per tick_ready rise while recording is enabled
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_d    <= 1'b0;
            out_wen   <= 1'b0;
            out_wdata <= '0;
            line      <= '0;
        end else begin
            tick_d  <= tick_ready;
            out_wen <= 1'b0;
            if (state == S_IDLE && start) begin
                line <= '0;
            end else if (tick_ready && !tick_d && spike_en) begin
                out_wen   <= 1'b1;
                out_wdata <= spike_out;
                line      <= line + OUT_AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_snn_packet_feeder.sv
// tb/tb_snn_packet_feeder.sv - directed self-checking bench for snn_packet_feeder
module tb_snn_packet_feeder;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [7:0]   num_picture;
    logic [7:0]   cnt_raddr;
    logic [11:0]  cnt_rdata;
    logic [13:0]  pkt_raddr;
    logic [29:0]  pkt_rdata;
    logic         packet_winc;
    logic [29:0]  packet_wdata;
    logic         spike_en;
    logic         load_end;
    logic [2:0]   grid_state;
    logic         tick_ready;
    logic [249:0] spike_out;
    logic         complete;
    logic         out_wen;
    logic [7:0]   out_waddr;
    logic [249:0] out_wdata;
    logic         busy;
    logic         done;

    logic [11:0]  cnt_rom [0:255];
    int           total = 0;
    int           passed = 0;

    snn_packet_feeder dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_picture(num_picture),
        .cnt_raddr(cnt_raddr), .cnt_rdata(cnt_rdata), .pkt_raddr(pkt_raddr),
        .pkt_rdata(pkt_rdata), .packet_winc(packet_winc), .packet_wdata(packet_wdata),
        .spike_en(spike_en), .load_end(load_end), .grid_state(grid_state),
        .tick_ready(tick_ready), .spike_out(spike_out), .complete(complete),
        .out_wen(out_wen), .out_waddr(out_waddr), .out_wdata(out_wdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous ROMs: count table from cnt_rom, packet k holds k+0x100
    always @(posedge clk) begin
        cnt_rdata <= cnt_rom[cnt_raddr];
        pkt_rdata <= 30'h100 + 30'(pkt_raddr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; start = 1'b0; complete = 1'b0; grid_state = 3'd0;
        tick_ready = 1'b0; spike_out = '0; num_picture = 8'd0;
        step(); step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic pulse_start(input logic [7:0] n);
        num_picture = n; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    function automatic logic [249:0] pat(input int p);
        logic [249:0] v;
        v = '0;
        v[p*40 +: 8] = 8'hA5 ^ 8'(p);
        v[249-p] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        do_reset();
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (packet_winc !== 1'b0) $display("FAIL reset_winc: got %b want 0", packet_winc); else passed++;
        total++; if (packet_wdata !== 30'h0) $display("FAIL reset_wdata: got %h want 0", packet_wdata); else passed++;
        total++; if ({load_end, spike_en, done, out_wen} !== 4'b0) $display("FAIL reset_ctrl: got %b want 0000", {load_end, spike_en, done, out_wen}); else passed++;
        total++; if (cnt_raddr !== 8'd0 || pkt_raddr !== 14'd0) $display("FAIL reset_addr: got %h/%h want 0/0", cnt_raddr, pkt_raddr); else passed++;
    endtask

    task automatic test_packets();
        logic [29:0] wdat [0:7];
        int          wcyc [0:7];
        int          nw;
        logic        hold_bad;
        do_reset();
        cnt_rom[0] = 12'd3; cnt_rom[1] = 12'd1;
        pulse_start(8'd2);
        nw = 0; hold_bad = 1'b0;
        for (int i = 0; i < 80 && !load_end; i++) begin
            if (grid_state == 3'd7) grid_state = 3'd0;
            if (packet_winc) begin
                if (nw < 8) begin wdat[nw] = packet_wdata; wcyc[nw] = i; end
                nw++;
                if (nw == 3 || nw == 4) grid_state = 3'd7;
            end else if (nw > 0 && packet_wdata !== wdat[(nw > 8 ? 8 : nw) - 1]) begin
                hold_bad = 1'b1;
            end
            step();
        end
        grid_state = 3'd0;
        total++; if (load_end !== 1'b1) $display("FAIL pkt_load_end: got %b want 1", load_end); else passed++;
        total++; if (nw != 4) $display("FAIL pkt_winc_count: got %0d want 4", nw); else passed++;
        for (int k = 0; k < 4 && k < nw; k++) begin
            total++; if (wdat[k] !== 30'h100 + 30'(k)) $display("FAIL pkt_wdata%0d: got %h want %h", k, wdat[k], 30'h100 + 30'(k)); else passed++;
        end
        for (int k = 0; k < 2 && k + 1 < nw; k++) begin
            total++; if (wcyc[k+1] - wcyc[k] != 2) $display("FAIL pkt_spacing%0d: got %0d want 2", k, wcyc[k+1] - wcyc[k]); else passed++;
        end
        total++; if (hold_bad) $display("FAIL pkt_wdata_hold: got changed want held"); else passed++;
    endtask

    task automatic test_complete();
        int low;
        low = 0;
        for (int i = 0; i < 10; i++) begin
            if (!load_end || !busy) low++;
            step();
        end
        total++; if (low != 0) $display("FAIL cpl_load_end_held: got %0d low cycles want 0", low); else passed++;
        complete = 1'b1;
        step();
        complete = 1'b0;
        total++; if (done !== 1'b1) $display("FAIL cpl_done: got %b want 1", done); else passed++;
        total++; if ({busy, load_end, spike_en} !== 3'b000) $display("FAIL cpl_outputs: got %b want 000", {busy, load_end, spike_en}); else passed++;
        step();
        total++; if (done !== 1'b0) $display("FAIL cpl_done_pulse: got %b want 0", done); else passed++;
    endtask

    task automatic test_stale_grid();
        int nw;
        int waited;
        do_reset();
        cnt_rom[0] = 12'd1; cnt_rom[1] = 12'd1;
        grid_state = 3'd7;
        pulse_start(8'd2);
        nw = 0;
        for (int i = 0; i < 15; i++) begin
            if (packet_winc) nw++;
            step();
        end
        total++; if (nw != 1) $display("FAIL stale_winc: got %0d want 1", nw); else passed++;
        total++; if (cnt_raddr !== 8'd0) $display("FAIL stale_no_advance: got %0d want 0", cnt_raddr); else passed++;
        grid_state = 3'd0; step();
        grid_state = 3'd7; step();
        waited = 0;
        while (cnt_raddr !== 8'd1 && waited < 6) begin step(); waited++; end
        total++; if (cnt_raddr !== 8'd1) $display("FAIL stale_advance: got %0d want 1", cnt_raddr); else passed++;
        for (int i = 0; i < 15; i++) step();
        total++; if (load_end !== 1'b0 || cnt_raddr !== 8'd1) $display("FAIL stale_held_pic1: got le=%b pic=%0d want le=0 pic=1", load_end, cnt_raddr); else passed++;
        grid_state = 3'd0;
    endtask

    task automatic test_warmup();
        int waited;
        int writes;
        do_reset();
        for (int p = 0; p < 5; p++) cnt_rom[p] = 12'd1;
        pulse_start(8'd5);
        writes = 0;
        for (int p = 0; p < 5; p++) begin
            waited = 0;
            while (!packet_winc && waited < 30) begin
                if (out_wen) writes++;
                step(); waited++;
            end
            total++; if (packet_winc !== 1'b1) $display("FAIL warm_winc_timeout%0d: got %b want 1", p, packet_winc); else passed++;
            total++; if (spike_en !== (p >= 3)) $display("FAIL warm_spike_en%0d: got %b want %b", p, spike_en, p >= 3); else passed++;
            tick_ready = 1'b1; grid_state = 3'd7; spike_out = pat(p);
            step();
            if (out_wen) writes++;
            total++; if (out_wen !== (p >= 3)) $display("FAIL warm_out_wen%0d: got %b want %b", p, out_wen, p >= 3); else passed++;
            if (p >= 3) begin
                total++; if (out_waddr !== 8'(p - 3)) $display("FAIL warm_waddr%0d: got %0d want %0d", p, out_waddr, p - 3); else passed++;
                total++; if (out_wdata !== pat(p)) $display("FAIL warm_wdata%0d: got %h want %h", p, out_wdata, pat(p)); else passed++;
            end
            tick_ready = 1'b0; grid_state = 3'd0; spike_out = '0;
            step();
            if (out_wen) writes++;
        end
        waited = 0;
        while (!load_end && waited < 10) begin step(); waited++; end
        total++; if (writes != 2) $display("FAIL warm_write_count: got %0d want 2", writes); else passed++;
        total++; if (load_end !== 1'b1 || spike_en !== 1'b1) $display("FAIL warm_load_end: got le=%b se=%b want 1/1", load_end, spike_en); else passed++;
    endtask

    task automatic test_zero_count();
        int waited;
        int nw;
        do_reset();
        cnt_rom[0] = 12'd1; cnt_rom[1] = 12'd0; cnt_rom[2] = 12'd1;
        pulse_start(8'd3);
        waited = 0;
        while (!packet_winc && waited < 20) begin step(); waited++; end
        total++; if (packet_wdata !== 30'h100) $display("FAIL zc_pic0_data: got %h want 100", packet_wdata); else passed++;
        grid_state = 3'd7; step(); grid_state = 3'd0;
        waited = 0;
        while (cnt_raddr !== 8'd1 && waited < 10) begin step(); waited++; end
        nw = 0;
        for (int i = 0; i < 8; i++) begin
            if (packet_winc) nw++;
            step();
        end
        total++; if (nw != 0) $display("FAIL zc_pic1_winc: got %0d want 0", nw); else passed++;
        total++; if (cnt_raddr !== 8'd1 || busy !== 1'b1) $display("FAIL zc_pic1_wait: got pic=%0d busy=%b want 1/1", cnt_raddr, busy); else passed++;
        grid_state = 3'd7; step(); grid_state = 3'd0;
        waited = 0;
        while (!packet_winc && waited < 20) begin step(); waited++; end
        total++; if (packet_winc !== 1'b1 || packet_wdata !== 30'h101) $display("FAIL zc_pic2_data: got %b/%h want 1/101", packet_winc, packet_wdata); else passed++;
        total++; if (cnt_raddr !== 8'd2) $display("FAIL zc_pic2_index: got %0d want 2", cnt_raddr); else passed++;
    endtask

    task automatic test_zero_pictures();
        do_reset();
        num_picture = 8'd0; start = 1'b1; complete = 1'b1;
        step();
        start = 1'b0; complete = 1'b0;
        total++; if (load_end !== 1'b1 || busy !== 1'b1 || done !== 1'b0) $display("FAIL zp_load_end: got le=%b busy=%b done=%b want 1/1/0", load_end, busy, done); else passed++;
        step(); step();
        total++; if (load_end !== 1'b1 || packet_winc !== 1'b0) $display("FAIL zp_hold: got le=%b winc=%b want 1/0", load_end, packet_winc); else passed++;
        complete = 1'b1; step(); complete = 1'b0;
        total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL zp_done: got done=%b busy=%b want 1/0", done, busy); else passed++;
    endtask

    task automatic test_reset_mid();
        int waited;
        do_reset();
        cnt_rom[0] = 12'd3;
        pulse_start(8'd1);
        waited = 0;
        while (!packet_winc && waited < 20) begin step(); waited++; end
        step(); step();
        total++; if (packet_winc !== 1'b1 || packet_wdata !== 30'h101) $display("FAIL rm_second_pkt: got %b/%h want 1/101", packet_winc, packet_wdata); else passed++;
        reset_n = 1'b0;
        step();
        total++; if (packet_winc !== 1'b0 || busy !== 1'b0) $display("FAIL rm_idle: got winc=%b busy=%b want 0/0", packet_winc, busy); else passed++;
        total++; if (pkt_raddr !== 14'd0 || cnt_raddr !== 8'd0 || packet_wdata !== 30'h0) $display("FAIL rm_counters: got %0d/%0d/%h want 0/0/0", pkt_raddr, cnt_raddr, packet_wdata); else passed++;
        reset_n = 1'b1;
        step();
        pulse_start(8'd1);
        waited = 0;
        while (!packet_winc && waited < 20) begin step(); waited++; end
        total++; if (packet_winc !== 1'b1 || packet_wdata !== 30'h100) $display("FAIL rm_replay: got %b/%h want 1/100", packet_winc, packet_wdata); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) cnt_rom[i] = 12'd0;
        test_reset();
        test_packets();
        test_complete();
        test_stale_grid();
        test_warmup();
        test_zero_count();
        test_zero_pictures();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
